fetch_unit: RTL

Program-counter and fetch-control stage that sits directly upstream of the instruction memory in the single-cycle RISC-V processor. It holds the architectural PC and drives the 6-bit word address into the 64-word instruction memory. It presents the returned instruction and its PC to decode. It sequences to the next PC, taken branch/jump target, halt or fault state each clock.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_next_pc.sv | 59 +++++
 rtl/fetch_unit.sv | 76 +++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: FSM states, fault codes,
// trap encodings and the byte-to-word address shift.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE    = 2'b10;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    localparam int unsigned WORD_SHIFT = 2;

    function automatic logic is_trap(input logic [31:0] insn);
        return (insn == INSN_ECALL) || (insn == INSN_EBREAK);
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC evaluator: applies redirect, trap and range rules in
// priority order and reports whether the current instruction retires.
module fetch_next_pc
    import fetch_unit_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  fetch_state_e i_state,
    input  logic         i_stall,
    input  logic         i_redirect,
    input  logic [31:0]  i_redirect_target,
    input  logic [31:0]  i_inst,
    input  logic [31:0]  i_pc,
    input  logic [1:0]   i_cause,
    output logic [31:0]  o_next_pc,
    output fetch_state_e o_next_state,
    output logic [1:0]   o_next_cause,
    output logic         o_retire
);

    // Range checks are 33 bits wide so pc+4 or a huge target never wraps back in.
    localparam logic [32:0] LIMIT = 33'(4 * MEM_WORDS);

    logic [32:0] w_pc_inc;
    logic [32:0] w_target_ext;

    assign w_pc_inc     = {1'b0, i_pc} + 33'd4;
    assign w_target_ext = {1'b0, i_redirect_target};

    always_comb begin
        o_next_pc    = i_pc;
        o_next_state = i_state;
        o_next_cause = i_cause;
        o_retire     = 1'b0;
        if (i_state == ST_RUN && !i_stall) begin
            if (i_redirect) begin
                if (i_redirect_target[1:0] != 2'b00) begin
                    o_next_state = ST_FAULT;
                    o_next_cause = CAUSE_MISALIGN;
                end else if (w_target_ext >= LIMIT) begin
                    o_next_state = ST_FAULT;
                    o_next_cause = CAUSE_RANGE;
                end else begin
                    o_next_pc = i_redirect_target;
                    o_retire  = 1'b1;
                end
            end else if (is_trap(i_inst)) begin
                o_next_state = ST_HALT;
            end else if (w_pc_inc >= LIMIT) begin
                o_next_state = ST_FAULT;
                o_next_cause = CAUSE_RANGE;
            end else begin
                o_next_pc = w_pc_inc[31:0];
                o_retire  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage top: architectural PC, FSM state, fault cause and retire counter
// registers around the combinational next-PC evaluator.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [5:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] retire_count
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [1:0]   r_cause;
    logic [31:0]  r_count;

    fetch_state_e w_next_state;
    logic [31:0]  w_next_pc;
    logic [1:0]   w_next_cause;
    logic         w_retire;

    fetch_next_pc #(
        .MEM_WORDS(MEM_WORDS)
    ) u_next_pc (
        .i_state          (r_state),
        .i_stall          (stall),
        .i_redirect       (redirect),
        .i_redirect_target(redirect_target),
        .i_inst           (imem_data),
        .i_pc             (r_pc),
        .i_cause          (r_cause),
        .o_next_pc        (w_next_pc),
        .o_next_state     (w_next_state),
        .o_next_cause     (w_next_cause),
        .o_retire         (w_retire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_state <= ST_RUN;
            r_cause <= CAUSE_NONE;
            r_count <= '0;
        end else begin
            r_pc    <= w_next_pc;
            r_state <= w_next_state;
            r_cause <= w_next_cause;
            if (w_retire) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign imem_addr    = r_pc[WORD_SHIFT +: 6];
    assign pc           = r_pc;
    assign inst         = imem_data;
    assign inst_valid   = (r_state == ST_RUN) && !rst;
    assign halted       = (r_state == ST_HALT);
    assign fault        = (r_state == ST_FAULT);
    assign fault_cause  = r_cause;
    assign retire_count = r_count;

endmodule
